fetch_pc_sequencer: RTL and testbench

//   Owns the fetch program counter and issues instruction-fetch addresses to instruction memory over a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_redirect_buffer.sv | 42 ++++
 rtl/fetch_pc_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch PC sequencer.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 32;
  localparam logic [ADDR_W_DEFAULT-1:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;
  localparam int unsigned PC_INC_DEFAULT = 4;

  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StRedirPend,
    StHalt
  } state_e;

endpackage

// File: rtl/fetch_redirect_buffer.sv
// Single-entry pending redirect target: newest write overwrites, clear on consume.
module fetch_redirect_buffer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] wr_data_i,
  input  logic              clr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [ADDR_W-1:0] data_d, data_q;

  // Clear wins over a same-cycle write: the consumer has already taken the newer target.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (wr_i) begin
      valid_d = 1'b1;
      data_d  = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: issues fetch addresses over valid/ready, applies branch redirects and halts.
module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W       = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned       PC_INC       = PC_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] BT,
  input  logic              halt_i,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] program_counter,
  output logic              fetch_flush,
  output logic              misalign_err
);

  localparam logic [ADDR_W-1:0] IncW = ADDR_W'(PC_INC);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              flush_d, flush_q;
  logic              mis_d, mis_q;

  logic              valid, xfer, redir;
  logic              buf_wr, buf_clr, pend_valid;
  logic [ADDR_W-1:0] pend_data;

  fetch_redirect_buffer #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buffer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_i      (buf_wr),
    .wr_data_i (BT),
    .clr_i     (buf_clr),
    .valid_o   (pend_valid),
    .data_o    (pend_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    buf_wr  = 1'b0;
    buf_clr = 1'b0;
    valid   = (state_q == StRun) || (state_q == StRedirPend);
    xfer    = valid && imem_req_ready;
    // A misaligned target is dropped outright; only the error pulse survives.
    mis_d   = branch_taken && (BT[1:0] != 2'b00);
    redir   = branch_taken && (BT[1:0] == 2'b00);
    if (xfer) pc_d = addr_q;

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        if (redir) begin
          addr_d  = BT;
          flush_d = 1'b1;
        end
      end
      StRun: begin
        if (xfer) begin
          addr_d  = redir ? BT : addr_q + IncW;
          flush_d = redir;
          state_d = halt_i ? StHalt : StRun;
        end else if (redir) begin
          buf_wr  = 1'b1;
          state_d = StRedirPend;
        end
      end
      StRedirPend: begin
        if (xfer) begin
          addr_d  = pend_data;
          flush_d = 1'b1;
          // Entering halt keeps the pending target alive as the resume address.
          if (halt_i) begin
            state_d = StHalt;
          end else begin
            buf_clr = 1'b1;
            state_d = StRun;
          end
        end else if (redir) begin
          buf_wr = 1'b1;
        end
      end
      StHalt: begin
        if (redir) buf_wr = 1'b1;
        if (!halt_i) begin
          state_d = StRun;
          buf_clr = 1'b1;
          if (redir) begin
            addr_d = BT;
          end else if (pend_valid) begin
            addr_d = pend_data;
          end
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StBoot;
      addr_q  <= RESET_VECTOR;
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req_valid  = valid;
  assign imem_addr       = addr_q;
  assign program_counter = pc_q;
  assign fetch_flush     = flush_q;
  assign misalign_err    = mis_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer with hand-computed expected values.
module tb_fetch_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] bt;
  logic        halt_i;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic [31:0] program_counter;
  logic        fetch_flush;
  logic        misalign_err;

  int n_total = 0;
  int n_bad   = 0;

  fetch_pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_taken    (branch_taken),
    .BT              (bt),
    .halt_i          (halt_i),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .program_counter (program_counter),
    .fetch_flush     (fetch_flush),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, " valid"}, 32'(imem_req_valid), 32'd0);
    check_eq({tag, " addr"}, imem_addr, 32'h8000_0000);
    check_eq({tag, " pc"}, program_counter, 32'h8000_0000);
    check_eq({tag, " flush"}, 32'(fetch_flush), 32'd0);
    check_eq({tag, " mis"}, 32'(misalign_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; branch_taken = 1'b0; bt = '0; halt_i = 1'b0; imem_req_ready = 1'b0;
    tick();
    check_reset("rst");

    // 1: boot then sequential fetch
    rst_n = 1'b1; imem_req_ready = 1'b1;
    tick();
    check_eq("boot valid", 32'(imem_req_valid), 32'd1);
    check_eq("boot addr", imem_addr, 32'h8000_0000);
    tick();
    check_eq("seq1 addr", imem_addr, 32'h8000_0004);
    check_eq("seq1 pc", program_counter, 32'h8000_0000);
    tick();
    check_eq("seq2 addr", imem_addr, 32'h8000_0008);
    check_eq("seq2 pc", program_counter, 32'h8000_0004);

    // 2: taken branch with transfer
    branch_taken = 1'b1; bt = 32'h8000_1234;
    tick();
    branch_taken = 1'b0;
    check_eq("br addr", imem_addr, 32'h8000_1234);
    check_eq("br pc", program_counter, 32'h8000_0008);
    check_eq("br flush", 32'(fetch_flush), 32'd1);
    tick();
    check_eq("br+1 addr", imem_addr, 32'h8000_1238);
    check_eq("br+1 flush", 32'(fetch_flush), 32'd0);

    // 3: two redirects while stalled, newest wins
    imem_req_ready = 1'b0; branch_taken = 1'b1; bt = 32'h8000_0010;
    tick();
    check_eq("pend1 addr", imem_addr, 32'h8000_1238);
    check_eq("pend1 valid", 32'(imem_req_valid), 32'd1);
    check_eq("pend1 flush", 32'(fetch_flush), 32'd0);
    bt = 32'h7FFF_FFF0;
    tick();
    check_eq("pend2 addr", imem_addr, 32'h8000_1238);
    branch_taken = 1'b0; imem_req_ready = 1'b1;
    tick();
    check_eq("pend xfer addr", imem_addr, 32'h7FFF_FFF0);
    check_eq("pend xfer pc", program_counter, 32'h8000_1238);
    check_eq("pend xfer flush", 32'(fetch_flush), 32'd1);
    tick();
    check_eq("pend+1 addr", imem_addr, 32'h7FFF_FFF4);
    check_eq("pend+1 flush", 32'(fetch_flush), 32'd0);

    // 4: misaligned redirect dropped
    branch_taken = 1'b1; bt = 32'h8000_0002;
    tick();
    branch_taken = 1'b0;
    check_eq("mis addr", imem_addr, 32'h7FFF_FFF8);
    check_eq("mis err", 32'(misalign_err), 32'd1);
    check_eq("mis flush", 32'(fetch_flush), 32'd0);
    tick();
    check_eq("mis+1 addr", imem_addr, 32'h7FFF_FFFC);
    check_eq("mis+1 err", 32'(misalign_err), 32'd0);

    // 5: wrap at top of address space
    branch_taken = 1'b1; bt = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check_eq("wrap0 addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap1 addr", imem_addr, 32'h0000_0000);
    check_eq("wrap1 pc", program_counter, 32'hFFFF_FFFC);

    // 6: halt waits for outstanding request, redirect in halt, resume
    imem_req_ready = 1'b0; halt_i = 1'b1;
    tick();
    check_eq("halt hold valid", 32'(imem_req_valid), 32'd1);
    check_eq("halt hold addr", imem_addr, 32'h0000_0000);
    imem_req_ready = 1'b1;
    tick();
    check_eq("halt valid", 32'(imem_req_valid), 32'd0);
    check_eq("halt pc", program_counter, 32'h0000_0000);
    branch_taken = 1'b1; bt = 32'h8000_0100;
    tick();
    branch_taken = 1'b0;
    check_eq("halt redir valid", 32'(imem_req_valid), 32'd0);
    check_eq("halt redir flush", 32'(fetch_flush), 32'd0);
    halt_i = 1'b0;
    tick();
    check_eq("resume valid", 32'(imem_req_valid), 32'd1);
    check_eq("resume addr", imem_addr, 32'h8000_0100);
    imem_req_ready = 1'b0;
    tick();
    check_eq("resume stall addr", imem_addr, 32'h8000_0100);

    // Reset in the middle of an outstanding request
    rst_n = 1'b0;
    tick();
    check_reset("rst2");
    rst_n = 1'b1; imem_req_ready = 1'b1;
    tick();
    check_eq("reboot addr", imem_addr, 32'h8000_0000);
    tick();
    check_eq("reboot seq addr", imem_addr, 32'h8000_0004);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
